// File: rtl/tape_ram_pkg.sv
// ============================================================================
// Module   : tape_ram_pkg
// Brief    : Shared FSM state type and default widths for the tape RAM.
// Revision : 1.0
// ============================================================================
`default_nettype none

package tape_ram_pkg;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   localparam int D_WIDTH_DEF = 8;
   localparam int A_WIDTH_DEF = 12;

endpackage

`default_nettype wire

// File: rtl/tape_ram_core.sv
// ============================================================================
// Module   : tape_ram_core
// Brief    : Bare SDP array, one write port, sync read, no reset.
//            TAPE_RAM_RMW_EN adds a second sync read port for add-writes.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tape_ram_core
   import tape_ram_pkg::*;
#(
   parameter int D_WIDTH = D_WIDTH_DEF,
   parameter int A_WIDTH = A_WIDTH_DEF,
   parameter int A_DEPTH = 1 << A_WIDTH
) (
   input  logic               clk,
   input  logic               we,
   input  logic [A_WIDTH-1:0] wa,
   input  logic [D_WIDTH-1:0] wd,
   input  logic               re,
   input  logic [A_WIDTH-1:0] ra,
   output logic [D_WIDTH-1:0] rd
`ifdef TAPE_RAM_RMW_EN
  ,input  logic               re2,
   input  logic [A_WIDTH-1:0] ra2,
   output logic [D_WIDTH-1:0] rd2
`endif
);

   logic [D_WIDTH-1:0] r_mem [A_DEPTH];

   // Both reads return the pre-write contents on a same-edge collision.
   always_ff @(posedge clk) begin
      if (we) r_mem[wa] <= wd;
      if (re) rd <= r_mem[ra];
   end

`ifdef TAPE_RAM_RMW_EN
   always_ff @(posedge clk) begin
      if (re2) rd2 <= r_mem[ra2];
   end
`endif

endmodule

`default_nettype wire

// File: rtl/tape_ram.sv
// ============================================================================
// Module   : tape_ram
// Brief    : SDP data/tape RAM with clear engine, write-first bypass and
//            range checks. Macro TAPE_RAM_RMW_EN enables 2-stage add-writes.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tape_ram
   import tape_ram_pkg::*;
#(
   parameter int D_WIDTH        = D_WIDTH_DEF,
   parameter int A_WIDTH        = A_WIDTH_DEF,
   parameter int A_DEPTH        = 1 << A_WIDTH,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clr,
   output logic               busy,
   input  logic               rce,
   input  logic [A_WIDTH-1:0] ra,
   output logic [D_WIDTH-1:0] rq,
   output logic               rvalid,
   input  logic               wce,
   input  logic [A_WIDTH-1:0] wa,
   input  logic [D_WIDTH-1:0] wd
`ifdef TAPE_RAM_RMW_EN
  ,input  logic               wadd
`endif
);

   localparam logic [A_WIDTH:0]   c_depth = (A_WIDTH+1)'(A_DEPTH);
   localparam logic [A_WIDTH-1:0] c_last  = A_WIDTH'(A_DEPTH - 1);

   state_t             r_state, w_state_nx;
   logic [A_WIDTH-1:0] r_ptr, w_ptr_nx;
   logic               w_busy, w_racc, w_wacc, w_rin, w_win, w_byp;
   logic               w_cw_en;
   logic [A_WIDTH-1:0] w_cw_addr;
   logic [D_WIDTH-1:0] w_cw_data;
   logic               w_mem_we, w_core_re;
   logic [A_WIDTH-1:0] w_mem_wa;
   logic [D_WIDTH-1:0] w_mem_wd, w_core_rd;
   logic               r_rvalid, r_rzero, r_rbyp;
   logic [D_WIDTH-1:0] r_bdata;
`ifdef TAPE_RAM_RMW_EN
   logic               r_s1_valid, r_s1_add, r_s1_fwd;
   logic [A_WIDTH-1:0] r_s1_addr;
   logic [D_WIDTH-1:0] r_s1_wd, r_s1_fdata, w_old, w_core_rd2;
`endif

   assign w_busy = (r_state == ST_CLEAR);
   assign busy   = w_busy;
   assign w_racc = rce & ~w_busy & ~clr;
   assign w_wacc = wce & ~w_busy & ~clr;
   assign w_rin  = ({1'b0, ra} < c_depth);
   assign w_win  = ({1'b0, wa} < c_depth);

   // ---------------------------------------------------------------- clear FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
         r_ptr   <= '0;
      end else begin
         r_state <= w_state_nx;
         r_ptr   <= w_ptr_nx;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_ptr_nx   = r_ptr;
      case (r_state)
         ST_IDLE: begin
            if (clr) begin
               w_state_nx = ST_CLEAR;
               w_ptr_nx   = '0;
            end
         end
         ST_CLEAR: begin
            if (r_ptr == c_last) begin
               w_state_nx = ST_IDLE;
               w_ptr_nx   = '0;
            end else begin
               w_ptr_nx = r_ptr + 1'b1;
            end
         end
         default: w_state_nx = ST_IDLE;
      endcase
   end

   // ------------------------------------------------- committing write source
`ifdef TAPE_RAM_RMW_EN
   // Old value comes from the array unless the previous commit hit the same word.
   assign w_old     = r_s1_fwd ? r_s1_fdata : w_core_rd2;
   assign w_cw_en   = r_s1_valid & ~clr;
   assign w_cw_addr = r_s1_addr;
   assign w_cw_data = r_s1_add ? (w_old + r_s1_wd) : r_s1_wd;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_add   <= 1'b0;
         r_s1_fwd   <= 1'b0;
         r_s1_addr  <= '0;
         r_s1_wd    <= '0;
         r_s1_fdata <= '0;
      end else begin
         r_s1_valid <= w_wacc & w_win;
         if (w_wacc & w_win) begin
            r_s1_addr  <= wa;
            r_s1_wd    <= wd;
            r_s1_add   <= wadd;
            r_s1_fwd   <= w_cw_en & (w_cw_addr == wa);
            r_s1_fdata <= w_cw_data;
         end
      end
   end
`else
   assign w_cw_en   = w_wacc & w_win;
   assign w_cw_addr = wa;
   assign w_cw_data = wd;
`endif

   assign w_mem_we  = w_busy | w_cw_en;
   assign w_mem_wa  = w_busy ? r_ptr : w_cw_addr;
   assign w_mem_wd  = w_busy ? '0 : w_cw_data;
   assign w_byp     = w_cw_en & (w_cw_addr == ra);
   assign w_core_re = w_racc & w_rin & ~w_byp;

   tape_ram_core #(
      .D_WIDTH (D_WIDTH),
      .A_WIDTH (A_WIDTH),
      .A_DEPTH (A_DEPTH)
   ) u_core (
      .clk (clk),
      .we  (w_mem_we),
      .wa  (w_mem_wa),
      .wd  (w_mem_wd),
      .re  (w_core_re),
      .ra  (ra),
      .rd  (w_core_rd)
`ifdef TAPE_RAM_RMW_EN
     ,.re2 (w_wacc & w_win),
      .ra2 (wa),
      .rd2 (w_core_rd2)
`endif
   );

   // ------------------------------------------------------------- read port
   // The select flags only move on an accepted read, so rq holds otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rvalid <= 1'b0;
         r_rzero  <= 1'b1;
         r_rbyp   <= 1'b0;
         r_bdata  <= '0;
      end else begin
         r_rvalid <= w_racc;
         if (w_racc) begin
            r_rzero <= ~w_rin;
            r_rbyp  <= w_byp;
            r_bdata <= w_cw_data;
         end
      end
   end

   assign rvalid = r_rvalid;
   assign rq     = r_rzero ? '0 : (r_rbyp ? r_bdata : w_core_rd);

endmodule

`default_nettype wire
